// File: rtl/control_hazard_if.sv
// control_hazard_if
//   Bundles the ID/EX-side signals of the control-hazard unit.
//   master : pipeline side (drives decode and resolve info, receives stall/flush)
//   slave  : control_hazard_unit side
// Signals
//   id_valid         ID stage holds a valid instruction
//   id_opcode[6:0]   inst[6:0] of the ID-stage instruction
//   ex_br_resolve    branch in EX resolves this cycle
//   ex_br_taken      resolved branch is taken (qualified by ex_br_resolve)
//   stall            hold PC and IF/ID register
//   flush            squash IF/ID contents (one-cycle pulse)
//   stall_remaining  stall cycles still to run including the current one
interface control_hazard_if #(
  parameter int CNT_W = 4
) ();
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic             ex_br_resolve;
  logic             ex_br_taken;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_remaining;

  modport master (
    output id_valid, id_opcode, ex_br_resolve, ex_br_taken,
    input  stall, flush, stall_remaining
  );

  modport slave (
    input  id_valid, id_opcode, ex_br_resolve, ex_br_taken,
    output stall, flush, stall_remaining
  );
endinterface

// File: rtl/control_hazard_unit.sv
// control_hazard_unit
//   Decodes the ID-stage opcode and holds the front end for a per-class
//   number of cycles after JAL / JALR / BRANCH. In predict-not-taken mode
//   branches do not stall; instead a taken branch resolved in EX produces a
//   one-cycle flush of IF/ID, which also aborts any stall in progress.
// Ports
//   clk   in   clock, all state on rising edge
//   res   in   synchronous active-high reset
//   bus   slave modport of control_hazard_if (decode/resolve in, stall/flush out)
//   perf_stall_cyc[31:0]  out  cycles with stall=1   (CTRL_HAZARD_PERF_EN only)
//   perf_flush_cnt[31:0]  out  cycles with flush=1   (CTRL_HAZARD_PERF_EN only)
// Configuration
//   `define CTRL_HAZARD_PERF_EN to add the two free-running perf counters.
module control_hazard_unit #(
  parameter int CNT_W      = 4,
  parameter int JAL_PEN    = 1,
  parameter int JALR_PEN   = 2,
  parameter int BR_PEN     = 2,
  parameter int PREDICT_NT = 0
) (
  input  logic              clk,
  input  logic              res,
  control_hazard_if.slave   bus
`ifdef CTRL_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] JAL_P  = CNT_W'(JAL_PEN);
  localparam logic [CNT_W-1:0] JALR_P = CNT_W'(JALR_PEN);
  // Branches never stall when predicting not-taken.
  localparam logic [CNT_W-1:0] BR_P   = (PREDICT_NT != 0) ? '0 : CNT_W'(BR_PEN);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             stall_r;
  logic             flush_r;

  logic [CNT_W-1:0] pen;
  logic             detect;
  logic             taken;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pen = '0;
    if (bus.id_valid) begin
      unique case (bus.id_opcode)
        OP_JAL:    pen = JAL_P;
        OP_JALR:   pen = JALR_P;
        OP_BRANCH: pen = BR_P;
        default:   pen = '0;
      endcase
    end
  end

  assign detect = (pen != '0);
  // Resolve inputs only matter in predict-not-taken mode.
  assign taken  = (PREDICT_NT != 0) && bus.ex_br_resolve && bus.ex_br_taken;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_r <= 1'b0;
      flush_r <= 1'b0;
    end else begin
      flush_r <= taken;
      if (taken) begin
        // Taken branch squashes the ID instruction: abort any stall and
        // ignore whatever is being decoded this edge.
        state   <= IDLE;
        cnt     <= '0;
        stall_r <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (detect) begin
              state   <= STALL;
              cnt     <= pen;
              stall_r <= 1'b1;
            end
          end
          STALL: begin
            // ID is frozen during the stall, so decode is ignored here.
            if (cnt == CNT_W'(1)) begin
              state   <= IDLE;
              cnt     <= '0;
              stall_r <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            stall_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.stall           = stall_r;
  assign bus.flush           = flush_r;
  assign bus.stall_remaining = cnt;

`ifdef CTRL_HAZARD_PERF_EN
  // Counters wrap naturally modulo 2**32.
  always_ff @(posedge clk) begin
    if (res) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_r) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush_r) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
